// File: rtl/tlk2711_rx_cmd.sv
// RX-side S2MM write-command generator: queues frame-length reports from the framer
// and issues one {addr, 8-byte-aligned len} command per frame, raising an irq after N frames.
module tlk2711_rx_cmd #(
  parameter int ADDR_WIDTH = 32,
  parameter int DLEN_WIDTH = 16,
  parameter int QDEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_soft_rst,
  input  logic                             i_rx_start,
  input  logic [ADDR_WIDTH-1:0]            i_rx_base_addr,
  input  logic [15:0]                      i_rx_frame_num,
  input  logic                             i_frame_vld,
  input  logic [15:0]                      i_frame_len,
  output logic                             o_wr_cmd_req,
  input  logic                             i_wr_cmd_ack,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_wr_cmd_data,
  input  logic                             i_dma_wr_done,
  output logic [15:0]                      o_rx_frame_cnt,
  output logic                             o_rx_irq,
  output logic                             o_q_overflow
);
  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, REQ, WAIT_DONE} state_t;

  state_t              state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]         n_frames;
  logic [15:0]         q_mem [QDEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         q_cnt;
  logic                q_full, q_empty, push_req, push, pop, last, clr;
  logic [16:0]         len_al;

  assign q_full   = (q_cnt == (AW+1)'(QDEPTH));
  assign q_empty  = (q_cnt == '0);
  assign push_req = i_frame_vld && (state != IDLE) && !i_rx_start && !i_soft_rst;
  assign push     = push_req && !q_full;
  assign pop      = (state == ARMED) && !q_empty && !i_rx_start && !i_soft_rst;
  assign last     = (state == WAIT_DONE) && i_dma_wr_done && (o_rx_frame_cnt + 16'd1 == n_frames);
  assign clr      = i_soft_rst || i_rx_start || last;

  // 17 bits so 0xFFF9..0xFFFF round to 0x10000 before narrowing to DLEN_WIDTH
  assign len_al = ({1'b0, q_mem[rd_ptr]} + 17'd7) & 17'h1fff8;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= i_frame_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      q_cnt <= q_cnt + (AW+1)'(1);
      else if (pop && !push) q_cnt <= q_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      n_frames       <= 16'd1;
      o_wr_cmd_req   <= 1'b0;
      o_wr_cmd_data  <= '0;
      o_rx_frame_cnt <= '0;
      o_rx_irq       <= 1'b0;
      o_q_overflow   <= 1'b0;
    end else if (i_soft_rst) begin
      state          <= IDLE;
      addr           <= '0;
      n_frames       <= 16'd1;
      o_wr_cmd_req   <= 1'b0;
      o_wr_cmd_data  <= '0;
      o_rx_frame_cnt <= '0;
      o_rx_irq       <= 1'b0;
      o_q_overflow   <= 1'b0;
    end else if (i_rx_start) begin
      // arm from IDLE and re-arm from any other state look the same
      state          <= ARMED;
      addr           <= i_rx_base_addr;
      n_frames       <= (i_rx_frame_num == 16'd0) ? 16'd1 : i_rx_frame_num;
      o_wr_cmd_req   <= 1'b0;
      o_rx_frame_cnt <= '0;
      o_rx_irq       <= 1'b0;
      o_q_overflow   <= 1'b0;
    end else begin
      o_rx_irq <= 1'b0;
      if (push_req && q_full) o_q_overflow <= 1'b1;
      case (state)
        ARMED: if (pop) begin
          o_wr_cmd_data <= {addr, DLEN_WIDTH'(len_al)};
          o_wr_cmd_req  <= 1'b1;
          state         <= REQ;
        end
        REQ: if (i_wr_cmd_ack) begin
          o_wr_cmd_req <= 1'b0;
          addr         <= addr + ADDR_WIDTH'(o_wr_cmd_data[DLEN_WIDTH-1:0]);
          state        <= WAIT_DONE;
        end
        WAIT_DONE: if (i_dma_wr_done) begin
          o_rx_frame_cnt <= o_rx_frame_cnt + 16'd1;
          if (last) begin
            o_rx_irq <= 1'b1;
            state    <= IDLE;
          end else begin
            state    <= ARMED;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tlk2711_rx_cmd.sv
// Scoreboard bench for tlk2711_rx_cmd: expected commands are queued as frames are
// reported and compared when the DUT raises its write-command request.
module tb_tlk2711_rx_cmd;
  localparam int AWD = 32;
  localparam int DLW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_soft_rst = 1'b0;
  logic            i_rx_start = 1'b0;
  logic [AWD-1:0]  i_rx_base_addr = '0;
  logic [15:0]     i_rx_frame_num = '0;
  logic            i_frame_vld = 1'b0;
  logic [15:0]     i_frame_len = '0;
  logic            o_wr_cmd_req;
  logic            i_wr_cmd_ack = 1'b0;
  logic [DLW+AWD-1:0] o_wr_cmd_data;
  logic            i_dma_wr_done = 1'b0;
  logic [15:0]     o_rx_frame_cnt;
  logic            o_rx_irq;
  logic            o_q_overflow;

  int checks = 0;
  int failures = 0;
  logic [DLW+AWD-1:0] exp_q [$];
  logic [AWD-1:0] exp_addr;
  int exp_cnt, exp_n;

  tlk2711_rx_cmd #(.ADDR_WIDTH(AWD), .DLEN_WIDTH(DLW), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_soft_rst(i_soft_rst), .i_rx_start(i_rx_start),
    .i_rx_base_addr(i_rx_base_addr), .i_rx_frame_num(i_rx_frame_num),
    .i_frame_vld(i_frame_vld), .i_frame_len(i_frame_len), .o_wr_cmd_req(o_wr_cmd_req),
    .i_wr_cmd_ack(i_wr_cmd_ack), .o_wr_cmd_data(o_wr_cmd_data), .i_dma_wr_done(i_dma_wr_done),
    .o_rx_frame_cnt(o_rx_frame_cnt), .o_rx_irq(o_rx_irq), .o_q_overflow(o_q_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int align8(input int len);
    return ((len + 7) / 8) * 8;
  endfunction

  task automatic arm(input logic [AWD-1:0] base, input int n);
    i_rx_start = 1'b1; i_rx_base_addr = base; i_rx_frame_num = 16'(n);
    tick();
    i_rx_start = 1'b0;
    exp_addr = base; exp_cnt = 0; exp_n = (n == 0) ? 1 : n;
    exp_q.delete();
  endtask

  task automatic pulse_raw(input int len);
    i_frame_vld = 1'b1; i_frame_len = 16'(len);
    tick();
    i_frame_vld = 1'b0;
  endtask

  task automatic pulse_vld(input int len);
    int al;
    al = align8(len);
    exp_q.push_back({exp_addr, DLW'(al)});
    exp_addr = exp_addr + AWD'(al);
    pulse_raw(len);
  endtask

  // act as the DMA engine for one command: optional stall, optional early done, ack, done
  task automatic serve(input int stall, input bit early_done);
    int k;
    logic [DLW+AWD-1:0] e;
    k = 0;
    while (!o_wr_cmd_req && k < 50) begin tick(); k++; end
    if (!o_wr_cmd_req) begin
      chk("req_timeout", 64'(o_wr_cmd_req), 64'd1);
      return;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("cmd_data", 64'(o_wr_cmd_data), 64'(e));
    for (int i = 0; i < stall; i++) begin
      if (early_done && i == 0) i_dma_wr_done = 1'b1;
      tick();
      i_dma_wr_done = 1'b0;
      chk("stall_req", 64'(o_wr_cmd_req), 64'd1);
      chk("stall_data", 64'(o_wr_cmd_data), 64'(e));
    end
    i_wr_cmd_ack = 1'b1;
    tick();
    i_wr_cmd_ack = 1'b0;
    chk("req_drop", 64'(o_wr_cmd_req), 64'd0);
    chk("cnt_pre_done", 64'(o_rx_frame_cnt), 64'(exp_cnt));
    i_dma_wr_done = 1'b1;
    tick();
    i_dma_wr_done = 1'b0;
    exp_cnt++;
    chk("cnt_post_done", 64'(o_rx_frame_cnt), 64'(exp_cnt));
    chk("irq", 64'(o_rx_irq), 64'(exp_cnt == exp_n));
  endtask

  initial begin
    tick();
    chk("rst_req", 64'(o_wr_cmd_req), 64'd0);
    chk("rst_data", 64'(o_wr_cmd_data), 64'd0);
    chk("rst_cnt", 64'(o_rx_frame_cnt), 64'd0);
    chk("rst_irq", 64'(o_rx_irq), 64'd0);
    chk("rst_ovf", 64'(o_q_overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic: three 870-byte frames, 2-cycle request latency on first
    arm(32'h1000_0000, 3);
    pulse_vld(870);
    chk("lat_cycle1", 64'(o_wr_cmd_req), 64'd0);
    tick();
    chk("lat_cycle2", 64'(o_wr_cmd_req), 64'd1);
    serve(0, 0);
    pulse_vld(870); serve(0, 0);
    pulse_vld(870); serve(0, 0);
    chk("basic_addr2", 64'(exp_addr), 64'h1000_0A38);
    tick();
    chk("irq_one_shot", 64'(o_rx_irq), 64'd0);
    chk("cnt_hold", 64'(o_rx_frame_cnt), 64'd3);
    pulse_raw(64);
    repeat (4) tick();
    chk("idle_ignores_frame", 64'(o_wr_cmd_req), 64'd0);

    // handshake stall with a premature done
    arm(32'h2000_0000, 5);
    pulse_vld(100);
    serve(20, 1);

    // burst of 6 while the first command sits in REQ
    arm(32'h3000_0000, 5);
    chk("arm_clears_cnt", 64'(o_rx_frame_cnt), 64'd0);
    for (int i = 0; i < 5; i++) pulse_vld(200 + i * 13);
    pulse_raw(999);
    tick();
    chk("ovf_set", 64'(o_q_overflow), 64'd1);
    for (int i = 0; i < 5; i++) serve(3, 0);
    chk("ovf_sticky", 64'(o_q_overflow), 64'd1);
    chk("burst_q_drained", 64'(exp_q.size()), 64'd0);

    // boundary lengths
    arm(32'h4000_0000, 4);
    chk("arm_clears_ovf", 64'(o_q_overflow), 64'd0);
    pulse_vld(0); serve(0, 0);
    pulse_vld(1); serve(0, 0);
    pulse_vld(8); serve(0, 0);
    pulse_vld(9); serve(0, 0);

    // address wrap
    arm(32'hFFFF_FFF8, 2);
    pulse_vld(16); serve(0, 0);
    pulse_vld(16); serve(0, 0);
    chk("wrap_model", 64'(exp_addr), 64'h0000_0018);

    // async reset while in REQ
    arm(32'h5000_0000, 3);
    pulse_vld(8); serve(0, 0);
    pulse_vld(8);
    tick();
    chk("pre_rst_req", 64'(o_wr_cmd_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(o_wr_cmd_req), 64'd0);
    chk("arst_data", 64'(o_wr_cmd_data), 64'd0);
    chk("arst_cnt", 64'(o_rx_frame_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_raw(8);
    repeat (4) tick();
    chk("post_arst_no_req", 64'(o_wr_cmd_req), 64'd0);

    // soft reset while in REQ
    arm(32'h6000_0000, 3);
    pulse_vld(24); serve(0, 0);
    pulse_vld(24);
    tick();
    i_soft_rst = 1'b1;
    #1;
    chk("srst_before_edge", 64'(o_wr_cmd_req), 64'd1);
    tick();
    i_soft_rst = 1'b0;
    chk("srst_req", 64'(o_wr_cmd_req), 64'd0);
    chk("srst_data", 64'(o_wr_cmd_data), 64'd0);
    chk("srst_cnt", 64'(o_rx_frame_cnt), 64'd0);
    pulse_raw(8);
    repeat (4) tick();
    chk("post_srst_no_req", 64'(o_wr_cmd_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
